// File: rtl/vec_lane_map.sv
// vec_lane_map: applies a scalar byte op to one selected byte of every element, LANES elements per beat.
// Define VEC_LANE_MAP_SAT_EN to saturate add at 0xFF and clamp sub at 0x00.
module vec_lane_map #(
    parameter int ELEMS = 16,
    parameter int EW = 64,
    parameter int LANES = 4,
    localparam int SW = (EW > 8) ? $clog2(EW / 8) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ELEMS*EW-1:0] in_vec,
    input  logic [31:0]         in_scalar,
    input  logic [SW-1:0]       in_sel,
    input  logic [1:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ELEMS*8-1:0]  out_res,
    output logic                busy
);
    localparam int BEATS = ELEMS / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [ELEMS*EW-1:0] vec_q;
    logic [7:0] scalar_q;
    logic [SW-1:0] sel_q;
    logic [1:0] op_q;
    logic [CW-1:0] beat;
    logic [ELEMS*8-1:0] res_q;
    logic [7:0] lane_res [LANES];
    logic accept, last, unused_scalar;

    assign accept = in_valid && in_ready;
    assign last = beat == CW'(BEATS - 1);
    assign out_res = res_q;
    assign unused_scalar = ^in_scalar[31:8];

    function automatic logic [7:0] apply(input logic [7:0] s, input logic [7:0] e, input logic [1:0] op);
        logic [7:0] sum, dif;
        sum = s + e;
        dif = s - e;
`ifdef VEC_LANE_MAP_SAT_EN
        if (op == 2'd0 && sum < s) return 8'hFF;
        if (op == 2'd1 && s < e) return 8'h00;
`endif
        return op == 2'd0 ? sum : op == 2'd1 ? dif : op == 2'd2 ? s ^ e : (s > e ? s : e);
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                  (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready = state == IDLE;
        busy = state != IDLE;
        out_valid = state == DONE;
    end

    // element index for lane l of the current beat; element 0 sits in the MSB slice
    always_comb begin
        for (int l = 0; l < LANES; l++)
            lane_res[l] = apply(scalar_q, vec_q[(ELEMS - 1 - (int'(beat) * LANES + l)) * EW + int'(sel_q) * 8 +: 8], op_q);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vec_q <= '0;
            scalar_q <= '0;
            sel_q <= '0;
            op_q <= '0;
            res_q <= '0;
            beat <= '0;
        end else if (accept) begin
            vec_q <= in_vec;
            scalar_q <= in_scalar[7:0];
            sel_q <= in_sel;
            op_q <= in_op;
            res_q <= '0;
            beat <= '0;
        end else if (state == RUN) begin
            for (int l = 0; l < LANES; l++)
                res_q[(ELEMS - 1 - (int'(beat) * LANES + l)) * 8 +: 8] <= lane_res[l];
            beat <= beat + CW'(1);
        end
endmodule

// File: tb/tb_vec_lane_map.sv
// tb_vec_lane_map: directed and random transactions against a per-element arithmetic model.
module tb_vec_lane_map;
    localparam int ELEMS = 16, EW = 64, LANES = 4;
    localparam int BEATS = ELEMS / LANES, VW = ELEMS * EW, RW = ELEMS * 8, SW = $clog2(EW / 8);
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, busy;
    logic [VW-1:0] in_vec = '0;
    logic [31:0] in_scalar = '0;
    logic [SW-1:0] in_sel = '0;
    logic [1:0] in_op = '0;
    logic [RW-1:0] out_res, last_res, exp_res;
    int errors = 0, checks = 0;

    vec_lane_map #(.ELEMS(ELEMS), .EW(EW), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .in_scalar(in_scalar), .in_sel(in_sel), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [VW-1:0] v, input int s, input int sel, input int op);
        logic [RW-1:0] r;
        int e, x;
        for (int k = 0; k < ELEMS; k++) begin
            e = int'(v[(ELEMS - 1 - k) * EW + sel * 8 +: 8]);
            case (op)
`ifdef VEC_LANE_MAP_SAT_EN
                0: x = (s + e > 255) ? 255 : s + e;
                1: x = (s - e < 0) ? 0 : s - e;
`else
                0: x = (s + e) % 256;
                1: x = (s - e + 256) % 256;
`endif
                2: x = s ^ e;
                default: x = s > e ? s : e;
            endcase
            r[(ELEMS - 1 - k) * 8 +: 8] = 8'(x);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [7:0] b);
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 8; i++) v[i * 8 +: 8] = b;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i * 32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic xact(input string tag, input logic [VW-1:0] v, input logic [7:0] s,
                        input int sel, input int op, input int stall);
        int n;
        logic [RW-1:0] exp;
        exp = model(v, int'(s), sel, op);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_in_ready"}, RW'(in_ready), RW'(1));
        in_vec = v;
        in_scalar = {24'($urandom()), s};
        in_sel = SW'(sel);
        in_op = 2'(op);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, "_latency"}, RW'(n), RW'(BEATS));
        check({tag, "_res"}, out_res, exp);
        last_res = out_res;
        for (int i = 0; i < stall; i++) begin
            in_valid = i[0];
            in_vec = rand_vec();
            @(negedge clk);
            check({tag, "_hold_res"}, out_res, exp);
            check({tag, "_hold_ctl"}, RW'({out_valid, in_ready, busy}), RW'(3'b101));
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check({tag, "_release"}, RW'({out_valid, in_ready, busy}), RW'(3'b010));
    endtask

    initial begin
        logic [VW-1:0] v;
        #12;
        check("reset_ctl", RW'({out_valid, in_ready, busy}), RW'(3'b010));
        check("reset_res", out_res, '0);
        @(negedge clk);
        rst = 0;

        v = rand_vec();
        for (int k = 0; k < ELEMS; k++) begin
            v[(ELEMS - 1 - k) * EW + 32 +: 8] = 8'(k);
            exp_res[(ELEMS - 1 - k) * 8 +: 8] = 8'(k + 5);
        end
        xact("add", v, 8'h05, 4, 0, 0);
        check("add_const", last_res, exp_res);

        xact("ovf", fill(8'h20), 8'hF0, 1, 0, 0);
`ifdef VEC_LANE_MAP_SAT_EN
        check("ovf_const", last_res, {ELEMS{8'hFF}});
`else
        check("ovf_const", last_res, {ELEMS{8'h10}});
`endif
        xact("sub", fill(8'h30), 8'h10, 2, 1, 0);
`ifdef VEC_LANE_MAP_SAT_EN
        check("sub_const", last_res, {ELEMS{8'h00}});
`else
        check("sub_const", last_res, {ELEMS{8'hE0}});
`endif
        xact("xor", fill(8'h30), 8'h10, 3, 2, 0);
        check("xor_const", last_res, {ELEMS{8'h20}});
        xact("max", fill(8'h30), 8'h10, 7, 3, 0);
        check("max_const", last_res, {ELEMS{8'h30}});

        xact("bp", rand_vec(), 8'($urandom()), 5, 3, 10);

        // abort two beats into a transaction
        @(negedge clk);
        in_vec = rand_vec();
        in_scalar = 32'h77;
        in_op = 0;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        check("abort_ctl", RW'({out_valid, in_ready, busy}), RW'(3'b010));
        check("abort_res", out_res, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_valid", RW'(out_valid), '0);
        end
        rst = 0;
        xact("post_abort", fill(8'h01), 8'h01, 0, 0, 0);
        check("post_abort_const", last_res, {ELEMS{8'h02}});

        for (int t = 0; t < 25; t++)
            xact("rand", rand_vec(), 8'($urandom()), $urandom_range(0, EW / 8 - 1),
                 $urandom_range(0, 3), $urandom_range(0, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_lane_map.md
VEC_LANE_MAP -- requirements
Module: vec_lane_map

Interface
REQ-001 SHALL have parameter ELEMS, default 16: number of vector elements; must be a multiple of LANES.
REQ-002 SHALL have parameter EW, default 64: element width in bits; EW/8 must be a power of two.
REQ-003 SHALL have parameter LANES, default 4: elements processed per clock beat.
REQ-004 SHALL have port clk  input  1: clock, rising-edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1: request valid.
REQ-007 SHALL have port in_ready  output  1: block accepts a request this cycle.
REQ-008 SHALL have port in_vec  input  ELEMS*EW: vector, element 0 in the MSB slice.
REQ-009 SHALL have port in_scalar  input  32: scalar operand; only bits [7:0] are used.
REQ-010 SHALL have port in_sel  input  clog2(EW/8): byte index within each element, byte 0 = bits [7:0].
REQ-011 SHALL have port in_op  input  2: operation; 0 add, 1 sub (scalar minus byte), 2 xor, 3 unsigned max.
REQ-012 SHALL have port out_valid  output  1: result valid.
REQ-013 SHALL have port out_ready  input  1: consumer accepts the result.
REQ-014 SHALL have port out_res  output  ELEMS*8: results, element 0 in the MSB byte.
REQ-015 SHALL have port busy  output  1: high in RUN or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready high only in IDLE.
REQ-018 SHALL, on in_valid && in_ready:
- register in_vec, in_scalar[7:0], in_sel and in_op;
- clear out_res to 0;
- clear the beat counter;
- go to RUN.
REQ-019 SHALL, in RUN beat b (0..ELEMS/LANES-1), compute elements b*LANES through b*LANES+LANES-1 and write each result byte into its out_res slot.
REQ-020 SHALL compute each element result from s = scalar byte and e = byte in_sel of that element.
REQ-021 SHALL make the arithmetic 8-bit unsigned, and wrap modulo 256 unless REQ-030 applies.
REQ-022 SHALL, on the edge that processes the last beat, go to DONE and assert out_valid; out_valid is therefore first high ELEMS/LANES edges after the accept edge (4 by default).
REQ-023 SHALL hold out_valid and out_res stable in DONE until out_ready is high; on that edge it returns to IDLE and deasserts out_valid.
REQ-024 SHALL ignore in_valid while in RUN or DONE; no request is queued.
REQ-025 SHALL allow, when out_ready is sampled high on the DONE edge, in_ready to rise the following cycle; there is no combinational ready path from out_ready to in_ready.
REQ-026 SHALL leave out_res undefined for consumers while out_valid is low; only partially filled bytes and zeros may appear on it.

Reset
REQ-027 SHALL, while rst is high, force state to IDLE and drive:
- out_valid=0, busy=0, in_ready=1;
- out_res=0, beat counter=0, operand registers=0.
REQ-028 SHALL, on rst during RUN or DONE, abandon the transaction with no output; the first request after rst release is processed correctly.

Configuration
REQ-029 SHALL use exactly one compile macro, VEC_LANE_MAP_SAT_EN.
REQ-030 SHALL, with VEC_LANE_MAP_SAT_EN defined, saturate add at 0xFF and clamp sub at 0x00; xor and max are unchanged.
REQ-031 SHALL, without VEC_LANE_MAP_SAT_EN, wrap add and sub modulo 256.

Verification
REQ-032 SHALL cover reset: assert rst mid-cycle -> immediately out_valid=0, in_ready=1, busy=0, out_res=0.
REQ-033 SHALL cover add, defaults: element k byte 4 = k, scalar 0x05, in_sel=4, in_op=0 -> element k result = k+5; out_valid exactly 4 edges after accept.
REQ-034 SHALL cover overflow: all bytes 0x20, scalar 0xF0, add -> every result 0x10 without the macro, 0xFF with it.
REQ-035 SHALL cover the other ops: scalar 0x10, bytes 0x30 ->
- sub = 0xE0 without the macro, 0x00 with it;
- xor = 0x20;
- max = 0x30.
REQ-036 SHALL cover backpressure: out_ready low for 10 cycles with in_valid pulsed -> out_valid/out_res stable, in_ready=0, pulse ignored; release -> IDLE next cycle.
REQ-037 SHALL cover abort: rst at beat 2 -> no out_valid; the next request (scalar 0x01, add, bytes 0x01) -> all results 0x02.
